// File: rtl/usb_txn_retry_fsm.sv
// Host-side USB transaction sequencer: issues token, DATA0 and handshake packets
// for one OUT or IN transfer and retries on NAK, timeout or corrupted responses.
module usb_txn_retry_fsm #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_ATTEMPTS   = 8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        txn_start,
    input  logic        txn_type,
    input  logic [6:0]  txn_addr,
    input  logic [3:0]  txn_endp,
    input  logic [63:0] txn_wdata,
    output logic        busy,
    output logic        txn_done,
    output logic        txn_success,
    output logic [63:0] txn_rdata,
    output logic        pkt_send,
    output logic [3:0]  pkt_pid,
    output logic [6:0]  pkt_addr,
    output logic [3:0]  pkt_endp,
    output logic [63:0] pkt_data,
    input  logic        pkt_sent,
    output logic        rx_en,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_error
);
    // state       | meaning
    // S_IDLE      | no transaction, waiting for txn_start
    // S_TOKEN     | OUT/IN token handed to encoder, waiting for pkt_sent
    // S_DATA      | DATA0 with latched payload handed to encoder
    // S_WAIT_HS   | receiver on, waiting for the device handshake (OUT)
    // S_WAIT_DATA | receiver on, waiting for the device DATA0 (IN)
    // S_SEND_ACK  | host ACK for good IN data, then success
    // S_SEND_NAK  | host NAK for corrupted IN data, then attempt fails
    // S_DONE      | txn_done pulse, back to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_TOKEN,
        S_DATA,
        S_WAIT_HS,
        S_WAIT_DATA,
        S_SEND_ACK,
        S_SEND_NAK,
        S_DONE
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    state_t         state;
    logic           lat_type;
    logic [AW-1:0]  attempt;
    logic [TW-1:0]  tmo_cnt;

    logic tmo_hit;
    logic can_retry;
    logic rx_ack_ok;
    logic rx_data_ok;
    logic attempt_fail;

    always_comb begin
        tmo_hit      = (tmo_cnt == TW'(TIMEOUT_CYCLES));
        can_retry    = (attempt < AW'(MAX_ATTEMPTS));
        rx_ack_ok    = rx_valid && !rx_error && (rx_pid == PID_ACK);
        rx_data_ok   = rx_valid && !rx_error && (rx_pid == PID_DATA0);
        attempt_fail = 1'b0;
        case (state)
            // a response in the same cycle as the timeout wins over the timeout
            S_WAIT_HS:   attempt_fail = rx_valid ? !rx_ack_ok : tmo_hit;
            S_WAIT_DATA: attempt_fail = rx_valid ? (!rx_error && !rx_data_ok) : tmo_hit;
            S_SEND_NAK:  attempt_fail = pkt_sent;
            default:     attempt_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state       <= S_IDLE;
            lat_type    <= 1'b0;
            attempt     <= '0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            txn_done    <= 1'b0;
            txn_success <= 1'b0;
            txn_rdata   <= '0;
            pkt_send    <= 1'b0;
            pkt_pid     <= '0;
            pkt_addr    <= '0;
            pkt_endp    <= '0;
            pkt_data    <= '0;
            rx_en       <= 1'b0;
        end else begin
            pkt_send <= 1'b0;
            txn_done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (txn_start) begin
                        lat_type    <= txn_type;
                        pkt_addr    <= txn_addr;
                        pkt_endp    <= txn_endp;
                        pkt_data    <= txn_wdata;
                        attempt     <= AW'(1);
                        busy        <= 1'b1;
                        txn_success <= 1'b0;
                        pkt_send    <= 1'b1;
                        pkt_pid     <= txn_type ? PID_IN : PID_OUT;
                        state       <= S_TOKEN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_TOKEN: begin
                    if (pkt_sent) begin
                        if (lat_type) begin
                            state   <= S_WAIT_DATA;
                            rx_en   <= 1'b1;
                            tmo_cnt <= '0;
                        end else begin
                            state    <= S_DATA;
                            pkt_send <= 1'b1;
                            pkt_pid  <= PID_DATA0;
                        end
                    end
                end
                S_DATA: begin
                    if (pkt_sent) begin
                        state   <= S_WAIT_HS;
                        rx_en   <= 1'b1;
                        tmo_cnt <= '0;
                    end
                end
                S_WAIT_HS: begin
                    if (rx_ack_ok) begin
                        state       <= S_DONE;
                        rx_en       <= 1'b0;
                        busy        <= 1'b0;
                        txn_done    <= 1'b1;
                        txn_success <= 1'b1;
                    end else if (!rx_valid && !tmo_hit) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WAIT_DATA: begin
                    if (rx_data_ok) begin
                        txn_rdata <= rx_data;
                        rx_en     <= 1'b0;
                        state     <= S_SEND_ACK;
                        pkt_send  <= 1'b1;
                        pkt_pid   <= PID_ACK;
                    end else if (rx_valid && rx_error) begin
                        rx_en    <= 1'b0;
                        state    <= S_SEND_NAK;
                        pkt_send <= 1'b1;
                        pkt_pid  <= PID_NAK;
                    end else if (!rx_valid && !tmo_hit) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_SEND_ACK: begin
                    if (pkt_sent) begin
                        state       <= S_DONE;
                        busy        <= 1'b0;
                        txn_done    <= 1'b1;
                        txn_success <= 1'b1;
                    end
                end
                S_SEND_NAK: begin
                    state <= S_SEND_NAK;
                end
            endcase

            // every failure path funnels through here so retry bookkeeping lives in one place
            if (attempt_fail) begin
                rx_en <= 1'b0;
                if (can_retry) begin
                    attempt  <= attempt + AW'(1);
                    state    <= S_TOKEN;
                    pkt_send <= 1'b1;
                    pkt_pid  <= lat_type ? PID_IN : PID_OUT;
                end else begin
                    state       <= S_DONE;
                    busy        <= 1'b0;
                    txn_done    <= 1'b1;
                    txn_success <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_txn_retry_fsm.sv
// Bench for usb_txn_retry_fsm: acts as encoder and device, checks directed table
// rows against fixed expectations and random transactions against an outcome model.
`timescale 1ns/1ps
module tb_usb_txn_retry_fsm;
    localparam int TMO  = 255;
    localparam int MAXA = 8;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_DATA0 = 4'b0011;
    localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010;
    localparam logic [2:0] R_ACK = 3'd0, R_NAK = 3'd1, R_ERR = 3'd2;
    localparam logic [2:0] R_TMO = 3'd3, R_DATA = 3'd4, R_OTHER = 3'd5;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        txn_start = 1'b0, txn_type = 1'b0;
    logic [6:0]  txn_addr = '0;
    logic [3:0]  txn_endp = '0;
    logic [63:0] txn_wdata = '0;
    logic        busy, txn_done, txn_success, pkt_send, rx_en;
    logic [63:0] txn_rdata, pkt_data;
    logic [3:0]  pkt_pid, pkt_endp;
    logic [6:0]  pkt_addr;
    logic        pkt_sent = 1'b0, rx_valid = 1'b0, rx_error = 1'b0;
    logic [3:0]  rx_pid = '0;
    logic [63:0] rx_data = '0;

    usb_txn_retry_fsm #(.TIMEOUT_CYCLES(TMO), .MAX_ATTEMPTS(MAXA)) dut (
        .clk(clk), .rst_L(rst_L),
        .txn_start(txn_start), .txn_type(txn_type), .txn_addr(txn_addr),
        .txn_endp(txn_endp), .txn_wdata(txn_wdata),
        .busy(busy), .txn_done(txn_done), .txn_success(txn_success), .txn_rdata(txn_rdata),
        .pkt_send(pkt_send), .pkt_pid(pkt_pid), .pkt_addr(pkt_addr), .pkt_endp(pkt_endp),
        .pkt_data(pkt_data), .pkt_sent(pkt_sent),
        .rx_en(rx_en), .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
    } pkt_t;

    typedef struct {
        logic             typ;
        logic [6:0]       addr;
        logic [3:0]       endp;
        logic [63:0]      wdata;
        logic [7:0][2:0]  resp;
        logic [7:0][8:0]  dly;
        logic [63:0]      rdev;
        int               tok, dat, ack, nak;
        logic             ok;
        logic [63:0]      rdata;
    } vec_t;

    int          n_cmp = 0, n_bad = 0;
    vec_t        tbl[8];
    pkt_t        pkt_q[$];
    logic [3:0]  exp_q[$];
    logic [63:0] model_rdata = '0;
    int          r_tok, r_dat, r_ack, r_nak;
    logic        r_ok;
    logic [63:0] r_rdata;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0][2:0] rseq(input logic [2:0] a0, a1, a2, rest);
        logic [7:0][2:0] s;
        for (int i = 0; i < 8; i++) s[i] = rest;
        s[0] = a0; s[1] = a1; s[2] = a2;
        return s;
    endfunction

    task automatic set_row(input int i, input logic typ, input logic [6:0] addr, input logic [3:0] endp,
                           input logic [63:0] wdata, input logic [7:0][2:0] resp, input logic [63:0] rdev,
                           input int dly, input int tok, dat, ack, nak, input logic ok, input logic [63:0] rdata);
        tbl[i].typ = typ; tbl[i].addr = addr; tbl[i].endp = endp; tbl[i].wdata = wdata;
        tbl[i].resp = resp; tbl[i].rdev = rdev;
        for (int a = 0; a < 8; a++) tbl[i].dly[a] = 9'(dly);
        tbl[i].tok = tok; tbl[i].dat = dat; tbl[i].ack = ack; tbl[i].nak = nak;
        tbl[i].ok = ok; tbl[i].rdata = rdata;
    endtask

    // Outcome model: attempts are consumed in order until one succeeds or the budget runs out.
    task automatic model(input vec_t v, output logic ok);
        exp_q.delete();
        ok = 1'b0;
        for (int a = 0; a < MAXA && !ok; a++) begin
            exp_q.push_back(v.typ ? P_IN : P_OUT);
            if (!v.typ) begin
                exp_q.push_back(P_DATA0);
                if (v.resp[a] == R_ACK) ok = 1'b1;
            end else if (v.resp[a] == R_DATA) begin
                exp_q.push_back(P_ACK);
                ok = 1'b1;
                model_rdata = v.rdev;
            end else if (v.resp[a] == R_ERR) begin
                exp_q.push_back(P_NAK);
            end
        end
    endtask

    task automatic run_txn(input vec_t v, input bit noise, input bit spur);
        int cyc, rem, w, att, aidx, bad_busy, bad_stab, nfb;
        bit enc_busy, prev_rx_en, done_seen;
        pkt_t cur;
        logic [2:0] r;
        cyc = 0; rem = 0; w = 0; att = 0; bad_busy = 0; bad_stab = 0; nfb = 0;
        enc_busy = 0; prev_rx_en = 0; done_seen = 0; cur = '0;
        pkt_q.delete();
        r_tok = 0; r_dat = 0; r_ack = 0; r_nak = 0; r_ok = 1'b0; r_rdata = '0;
        @(negedge clk);
        txn_type = v.typ; txn_addr = v.addr; txn_endp = v.endp; txn_wdata = v.wdata; txn_start = 1'b1;
        @(negedge clk);
        txn_type = 1'($urandom); txn_addr = 7'($urandom); txn_endp = 4'($urandom);
        txn_wdata = {$urandom, $urandom};
        while (!done_seen && cyc < 20000) begin
            txn_start = 1'b0; pkt_sent = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
            rx_pid = 4'($urandom); rx_data = {$urandom, $urandom};
            if (txn_done) begin
                done_seen = 1;
                r_ok = txn_success;
                r_rdata = txn_rdata;
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end else begin
                if (!busy) bad_busy++;
                if (spur && cyc == 2) begin
                    txn_start = 1'b1; txn_type = ~v.typ; txn_addr = v.addr ^ 7'h7f; txn_endp = ~v.endp;
                end
                if (pkt_send) begin
                    if (enc_busy) bad_stab++;
                    cur = {pkt_pid, pkt_addr, pkt_endp, pkt_data};
                    pkt_q.push_back(cur);
                    if (pkt_pid == P_OUT || pkt_pid == P_IN) att++;
                    enc_busy = 1;
                    rem = $urandom_range(0, 3);
                end else if (enc_busy && {pkt_pid, pkt_addr, pkt_endp, pkt_data} != cur) begin
                    bad_stab++;
                end
                if (enc_busy) begin
                    if (rem == 0) begin pkt_sent = 1'b1; enc_busy = 0; end
                    else rem--;
                end
                if (rx_en) begin
                    if (!prev_rx_en) w = 0;
                    aidx = (att >= 1 && att <= MAXA) ? att - 1 : 0;
                    r = (att >= 1 && att <= MAXA) ? v.resp[aidx] : R_TMO;
                    if (r != R_TMO && w == int'(v.dly[aidx])) begin
                        rx_valid = 1'b1;
                        case (r)
                            R_ACK:   rx_pid = P_ACK;
                            R_NAK:   rx_pid = P_NAK;
                            R_ERR:   rx_error = 1'b1;
                            R_DATA:  begin rx_pid = P_DATA0; rx_data = v.rdev; end
                            default: rx_pid = v.typ ? P_ACK : P_DATA0;
                        endcase
                    end else if (noise && !enc_busy && $urandom_range(0, 7) == 0) begin
                        pkt_sent = 1'b1;
                    end
                    w++;
                end else if (noise && $urandom_range(0, 7) == 0) begin
                    rx_valid = 1'b1;
                    rx_pid = v.typ ? P_DATA0 : P_ACK;
                end
            end
            prev_rx_en = rx_en;
            cyc++;
            @(negedge clk);
        end
        pkt_sent = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; txn_start = 1'b0;
        if (!done_seen) begin
            check("done_within_budget", 64'd0, 64'd1);
        end else begin
            check("done_one_cycle", {63'd0, txn_done}, 64'd0);
            check("busy_after_done", {63'd0, busy}, 64'd0);
        end
        foreach (pkt_q[i]) begin
            if (pkt_q[i].pid == P_OUT || pkt_q[i].pid == P_IN) begin
                r_tok++;
                if (pkt_q[i].pid != (v.typ ? P_IN : P_OUT) || pkt_q[i].addr != v.addr ||
                    pkt_q[i].endp != v.endp) nfb++;
            end else if (pkt_q[i].pid == P_DATA0) begin
                r_dat++;
                if (pkt_q[i].data != v.wdata) nfb++;
            end else if (pkt_q[i].pid == P_ACK) r_ack++;
            else if (pkt_q[i].pid == P_NAK) r_nak++;
            else nfb++;
        end
        check("pkt_fields_bad", 64'(nfb), 64'd0);
        check("busy_low_cycles", 64'(bad_busy), 64'd0);
        check("pkt_unstable", 64'(bad_stab), 64'd0);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic ok_exp;
        int k, nseq, seen_done;

        set_row(0, 1'b0, 7'h05, 4'h4, 64'hCAFEBABEDEADBEEF, rseq(R_ACK, R_ACK, R_ACK, R_ACK), 64'h0, 3,
                1, 1, 0, 0, 1'b1, 64'h0);
        set_row(1, 1'b0, 7'h05, 4'h4, 64'h0123456789ABCDEF, rseq(R_ERR, R_ACK, R_ACK, R_ACK), 64'h0, 0,
                2, 2, 0, 0, 1'b1, 64'h0);
        set_row(2, 1'b1, 7'h12, 4'h7, 64'h0, rseq(R_TMO, R_DATA, R_DATA, R_DATA), 64'hCAFEBABEDEADBEEF, TMO - 1,
                2, 0, 1, 0, 1'b1, 64'hCAFEBABEDEADBEEF);
        set_row(3, 1'b1, 7'h12, 4'h7, 64'h0, rseq(R_NAK, R_NAK, R_DATA, R_DATA), 64'h0123456789ABCDEF, 6,
                3, 0, 1, 0, 1'b1, 64'h0123456789ABCDEF);
        set_row(4, 1'b1, 7'h33, 4'h1, 64'h0, rseq(R_ERR, R_ERR, R_ERR, R_ERR), 64'hFFFFFFFFFFFFFFFF, 2,
                8, 0, 0, 8, 1'b0, 64'h0123456789ABCDEF);
        set_row(5, 1'b0, 7'h7F, 4'hF, 64'h5555AAAA5555AAAA, rseq(R_NAK, R_NAK, R_NAK, R_NAK), 64'h0, 1,
                8, 8, 0, 0, 1'b0, 64'h0123456789ABCDEF);
        set_row(6, 1'b1, 7'h00, 4'h0, 64'h0, rseq(R_OTHER, R_DATA, R_DATA, R_DATA), 64'h1122334455667788, 0,
                2, 0, 1, 0, 1'b1, 64'h1122334455667788);
        set_row(7, 1'b0, 7'h2A, 4'h9, 64'hFEEDFACE00C0FFEE, rseq(R_OTHER, R_TMO, R_ACK, R_ACK), 64'h0, 5,
                3, 3, 0, 0, 1'b1, 64'h1122334455667788);

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, txn_done, txn_success, pkt_send, rx_en, pkt_pid, pkt_addr, pkt_endp}), 64'd0);
        check("reset_rdata", txn_rdata, 64'd0);
        check("reset_pdata", pkt_data, 64'd0);
        rst_L = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], 1'b0, (i == 1 || i == 3));
            check($sformatf("row%0d_tokens", i), 64'(r_tok), 64'(tbl[i].tok));
            check($sformatf("row%0d_data0", i), 64'(r_dat), 64'(tbl[i].dat));
            check($sformatf("row%0d_acks", i), 64'(r_ack), 64'(tbl[i].ack));
            check($sformatf("row%0d_naks", i), 64'(r_nak), 64'(tbl[i].nak));
            check($sformatf("row%0d_success", i), {63'd0, r_ok}, {63'd0, tbl[i].ok});
            check($sformatf("row%0d_rdata", i), r_rdata, tbl[i].rdata);
            model_rdata = tbl[i].rdata;
        end

        // reset in the middle of an IN transfer, while waiting for device data
        @(negedge clk);
        txn_type = 1'b1; txn_addr = 7'h11; txn_endp = 4'h2; txn_start = 1'b1;
        @(negedge clk);
        txn_start = 1'b0;
        k = 0;
        while (!rx_en && k < 50) begin
            pkt_sent = pkt_send;
            @(negedge clk);
            k++;
        end
        pkt_sent = 1'b0;
        check("rst_mid_reached_wait", {63'd0, rx_en}, 64'd1);
        repeat (2) @(negedge clk);
        rst_L = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({busy, txn_done, txn_success, pkt_send, rx_en, pkt_pid, pkt_addr, pkt_endp}), 64'd0);
        check("rst_mid_rdata", txn_rdata, 64'd0);
        check("rst_mid_pdata", pkt_data, 64'd0);
        seen_done = 0;
        repeat (2) begin @(negedge clk); seen_done += int'(txn_done); end
        rst_L = 1'b1;
        repeat (4) begin @(negedge clk); seen_done += int'(txn_done) + int'(busy); end
        check("rst_mid_no_done", 64'(seen_done), 64'd0);
        model_rdata = '0;
        run_txn(tbl[0], 1'b0, 1'b0);
        check("post_rst_tokens", 64'(r_tok), 64'd1);
        check("post_rst_data0", 64'(r_dat), 64'd1);
        check("post_rst_success", {63'd0, r_ok}, 64'd1);
        check("post_rst_rdata", r_rdata, 64'd0);

        for (int t = 0; t < 40; t++) begin
            v.typ = 1'($urandom); v.addr = 7'($urandom); v.endp = 4'($urandom);
            v.wdata = {$urandom, $urandom}; v.rdev = {$urandom, $urandom};
            for (int a = 0; a < 8; a++) begin
                k = $urandom_range(0, 9);
                v.resp[a] = (k <= 2) ? (v.typ ? R_DATA : R_ACK) : (k <= 4) ? R_NAK :
                            (k <= 6) ? R_ERR : (k == 7) ? R_TMO : R_OTHER;
                v.dly[a] = ($urandom_range(0, 9) == 0) ? 9'(TMO - 1) : 9'($urandom_range(0, 12));
            end
            run_txn(v, 1'b1, (t % 5) == 0);
            model(v, ok_exp);
            check("rnd_pkt_count", 64'(pkt_q.size()), 64'(exp_q.size()));
            nseq = 0;
            for (int i = 0; i < exp_q.size() && i < pkt_q.size(); i++)
                if (pkt_q[i].pid != exp_q[i]) nseq++;
            check("rnd_pid_seq", 64'(nseq), 64'd0);
            check("rnd_success", {63'd0, r_ok}, {63'd0, ok_exp});
            check("rnd_rdata", r_rdata, model_rdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
